// File: rtl/pcs_rx_pkg.sv
// rtl/pcs_rx_pkg.sv - shared 64b/66b receive constants, block classes and rx states
package pcs_rx_pkg;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam logic [7:0] BT_IDLE = 8'h1E;
    localparam logic [7:0] BT_OS   = 8'h4B;
    localparam logic [7:0] BT_S    = 8'h78;
    localparam logic [7:0] BT_T0   = 8'h87;
    localparam logic [7:0] BT_T1   = 8'h99;
    localparam logic [7:0] BT_T2   = 8'hAA;
    localparam logic [7:0] BT_T3   = 8'hB4;
    localparam logic [7:0] BT_T4   = 8'hCC;
    localparam logic [7:0] BT_T5   = 8'hD2;
    localparam logic [7:0] BT_T6   = 8'hE1;
    localparam logic [7:0] BT_T7   = 8'hFF;

    // Eight 7-bit /E/ codes (7'h1E) packed behind an idle-type control header.
    localparam logic [65:0] EBLOCK     = {SH_CTRL, BT_IDLE, 56'h3C78F1E3C78F1E};
    localparam logic [65:0] IDLE_BLOCK = {SH_CTRL, BT_IDLE, 56'h0};

    typedef enum logic [2:0] {
        BLK_C,
        BLK_D,
        BLK_S,
        BLK_T,
        BLK_E
    } blk_class_t;

    typedef enum logic [2:0] {
        RX_INIT,
        RX_C,
        RX_D,
        RX_T,
        RX_E
    } rx_state_t;

    function automatic logic is_t_type(input logic [7:0] block_type);
        case (block_type)
            BT_T0, BT_T1, BT_T2, BT_T3,
            BT_T4, BT_T5, BT_T6, BT_T7: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rx_block_classifier.sv
// rtl/rx_block_classifier.sv - combinational C/D/S/T/E classification of a 66-bit block head
module rx_block_classifier
    import pcs_rx_pkg::*;
(
    input  logic [9:0] block_head,
    output logic [2:0] block_class
);

    logic [1:0] sync_header;
    logic [7:0] block_type;
    blk_class_t cls;

    assign sync_header = block_head[9:8];
    assign block_type  = block_head[7:0];

    always_comb begin
        cls = BLK_E;
        if (sync_header == SH_DATA) begin
            cls = BLK_D;
        end else if (sync_header == SH_CTRL) begin
            if (block_type == BT_IDLE || block_type == BT_OS) begin
                cls = BLK_C;
            end else if (block_type == BT_S) begin
                cls = BLK_S;
            end else if (is_t_type(block_type)) begin
                cls = BLK_T;
            end
        end
    end

    assign block_class = cls;

endmodule

// File: rtl/rx_block_sequence_checker.sv
// rtl/rx_block_sequence_checker.sv - 64b/66b receive sequencing check with one-block lookahead
module rx_block_sequence_checker
    import pcs_rx_pkg::*;
#(
    parameter int LEN_CODED_BLOCK = 66,
    parameter int NB_ERR_CNT      = 16
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_valid,
    input  logic [LEN_CODED_BLOCK-1:0] i_data,
    input  logic                       i_tag,
    input  logic                       i_clear_count,
    output logic [LEN_CODED_BLOCK-1:0] o_data,
    output logic                       o_valid,
    output logic                       o_tag,
    output logic [NB_ERR_CNT-1:0]      o_error_count
);

    logic [LEN_CODED_BLOCK-1:0] cur_data;
    logic                       cur_tag;
    logic                       cur_full;
    rx_state_t                  state;
    rx_state_t                  next_state;
    logic [2:0]                 cur_class_raw;
    logic [2:0]                 la_class_raw;
    blk_class_t                 cur_class;
    blk_class_t                 la_class;
    logic                       accept;
    logic                       decide;
    logic                       t_ok;
    logic                       err_inc;

    assign accept = i_enable & i_valid;
    // A held block is only resolved once its successor arrives to serve as lookahead.
    assign decide = accept & cur_full;

    rx_block_classifier u_cur_classifier (
        .block_head  (cur_data[LEN_CODED_BLOCK-1 -: 10]),
        .block_class (cur_class_raw)
    );

    rx_block_classifier u_la_classifier (
        .block_head  (i_data[LEN_CODED_BLOCK-1 -: 10]),
        .block_class (la_class_raw)
    );

    assign cur_class = blk_class_t'(cur_class_raw);
    assign la_class  = blk_class_t'(la_class_raw);
    assign t_ok      = (cur_class == BLK_T) && (la_class == BLK_S || la_class == BLK_C);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= RX_INIT;
        end else if (decide) begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = RX_E;
        case (state)
            RX_D: begin
                if (cur_class == BLK_D) begin
                    next_state = RX_D;
                end else if (t_ok) begin
                    next_state = RX_T;
                end
            end
            RX_E: begin
                if (cur_class == BLK_C) begin
                    next_state = RX_C;
                end else if (cur_class == BLK_D) begin
                    next_state = RX_D;
                end else if (t_ok) begin
                    next_state = RX_T;
                end
            end
            default: begin
                if (cur_class == BLK_C) begin
                    next_state = RX_C;
                end else if (cur_class == BLK_S) begin
                    next_state = RX_D;
                end
            end
        endcase
    end

    assign err_inc = decide && (next_state == RX_E);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cur_data <= '0;
            cur_tag  <= 1'b0;
            cur_full <= 1'b0;
            o_data   <= EBLOCK;
            o_valid  <= 1'b0;
            o_tag    <= 1'b0;
        end else if (i_enable) begin
            o_valid <= decide;
            if (decide) begin
                o_data <= (next_state == RX_E) ? EBLOCK : cur_data;
                o_tag  <= cur_tag;
            end
            if (accept) begin
                cur_data <= i_data;
                cur_tag  <= i_tag;
                cur_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_error_count <= '0;
        end else if (i_enable) begin
            if (i_clear_count) begin
                o_error_count <= '0;
            end else if (err_inc && (o_error_count != {NB_ERR_CNT{1'b1}})) begin
                o_error_count <= o_error_count + NB_ERR_CNT'(1);
            end
        end
    end

endmodule

// File: tb/tb_rx_block_sequence_checker.sv
// tb/tb_rx_block_sequence_checker.sv - table-driven bench for rx_block_sequence_checker
module tb_rx_block_sequence_checker;
    import pcs_rx_pkg::*;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        i_valid;
    logic [65:0] i_data;
    logic        i_tag;
    logic        i_clear_count;
    logic [65:0] o_data;
    logic        o_valid;
    logic        o_tag;
    logic [15:0] o_error_count;

    rx_block_sequence_checker #(
        .LEN_CODED_BLOCK (66),
        .NB_ERR_CNT      (16)
    ) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .i_tag         (i_tag),
        .i_clear_count (i_clear_count),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_tag         (o_tag),
        .o_error_count (o_error_count)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic        en;
        logic        vld;
        logic [65:0] data;
        logic        tag;
        logic        ev;
        logic [65:0] ed;
        logic        et;
        logic        cs;
        rx_state_t   es;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [65:0] s1, d1, d2, d3, t87, tff, bad;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input logic en, input logic vld, input logic [65:0] data,
                        input logic tag, input logic clr);
        i_enable      = en;
        i_valid       = vld;
        i_data        = data;
        i_tag         = tag;
        i_clear_count = clr;
        @(negedge i_clock);
    endtask

    task automatic reset_dut();
        i_reset = 1'b1;
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        i_reset = 1'b0;
    endtask

    function automatic void add(input logic en, input logic vld, input logic [65:0] data,
                                input logic tag, input logic ev, input logic [65:0] ed,
                                input logic et, input logic cs, input rx_state_t es);
        vec_t v;
        v.en = en; v.vld = vld; v.data = data; v.tag = tag;
        v.ev = ev; v.ed = ed; v.et = et; v.cs = cs; v.es = es;
        vq.push_back(v);
    endfunction

    task automatic run_vecs(input string name);
        foreach (vq[i]) begin
            step(vq[i].en, vq[i].vld, vq[i].data, vq[i].tag, 1'b0);
            check($sformatf("%s[%0d].valid", name, i), 66'(o_valid), 66'(vq[i].ev));
            if (vq[i].ev) begin
                check($sformatf("%s[%0d].data", name, i), o_data, vq[i].ed);
                check($sformatf("%s[%0d].tag", name, i), 66'(o_tag), 66'(vq[i].et));
            end
            if (vq[i].cs) begin
                check($sformatf("%s[%0d].state", name, i), 66'(dut.state), 66'(vq[i].es));
            end
        end
        vq.delete();
    endtask

    initial begin
        s1  = {SH_CTRL, BT_S, 56'h00112233445566};
        d1  = {SH_DATA, 64'h0123456789ABCDEF};
        d2  = {SH_DATA, 64'hFEDCBA9876543210};
        d3  = {SH_DATA, 64'h5A5A5A5AA5A5A5A5};
        t87 = {SH_CTRL, BT_T0, 56'h0};
        tff = {SH_CTRL, BT_T7, 56'h0};
        bad = {2'b00, 64'hDEADBEEFCAFEF00D};
        i_reset = 1'b1; i_enable = 1'b0; i_valid = 1'b0;
        i_data = '0; i_tag = 1'b0; i_clear_count = 1'b0;

        reset_dut();
        check("reset.data", o_data, EBLOCK);
        check("reset.valid", 66'(o_valid), 66'(0));
        check("reset.tag", 66'(o_tag), 66'(0));
        check("reset.count", 66'(o_error_count), 66'(0));
        check("reset.state", 66'(dut.state), 66'(RX_INIT));

        // Idle stream with alternating tags
        for (int i = 0; i < 10; i++)
            add(1, 1, IDLE_BLOCK, logic'(i % 2), i > 0, IDLE_BLOCK, logic'((i + 1) % 2), i > 0, RX_C);
        run_vecs("idle");
        check("idle.count", 66'(o_error_count), 66'(0));

        reset_dut();
        add(1, 1, IDLE_BLOCK, 1, 0, '0,         0, 0, RX_INIT);
        add(1, 1, s1,         0, 1, IDLE_BLOCK, 1, 1, RX_C);
        add(1, 1, d1,         1, 1, s1,         0, 1, RX_D);
        add(1, 1, d2,         1, 1, d1,         1, 1, RX_D);
        add(1, 1, t87,        0, 1, d2,         1, 1, RX_D);
        add(1, 1, IDLE_BLOCK, 1, 1, t87,        0, 1, RX_T);
        add(1, 1, IDLE_BLOCK, 0, 1, IDLE_BLOCK, 1, 1, RX_C);
        run_vecs("packet");
        check("packet.count", 66'(o_error_count), 66'(0));

        // T followed by D is not a legal terminate
        reset_dut();
        add(1, 1, s1,         0, 0, '0,     0, 0, RX_INIT);
        add(1, 1, d1,         1, 1, s1,     0, 1, RX_D);
        add(1, 1, tff,        0, 1, d1,     1, 1, RX_D);
        add(1, 1, d2,         1, 1, EBLOCK, 0, 1, RX_E);
        add(1, 1, IDLE_BLOCK, 0, 1, d2,     1, 1, RX_D);
        run_vecs("badla");
        check("badla.count", 66'(o_error_count), 66'(1));

        reset_dut();
        add(1, 1, s1,         1, 0, '0,     0, 0, RX_INIT);
        add(1, 1, d1,         0, 1, s1,     1, 1, RX_D);
        add(1, 1, bad,        1, 1, d1,     0, 1, RX_D);
        add(1, 1, d2,         0, 1, EBLOCK, 1, 1, RX_E);
        add(1, 1, t87,        1, 1, d2,     0, 1, RX_D);
        add(1, 1, IDLE_BLOCK, 0, 1, t87,    1, 1, RX_T);
        run_vecs("badhdr");
        check("badhdr.count", 66'(o_error_count), 66'(1));

        // Valid gaps and an enable-low window carrying junk that must be ignored
        reset_dut();
        add(1, 1, IDLE_BLOCK, 0, 0, '0,         0, 0, RX_INIT);
        add(1, 0, bad,        1, 0, '0,         0, 0, RX_INIT);
        add(1, 1, s1,         1, 1, IDLE_BLOCK, 0, 1, RX_C);
        add(1, 0, bad,        0, 0, '0,         0, 1, RX_C);
        add(1, 1, d1,         0, 1, s1,         1, 1, RX_D);
        add(1, 0, bad,        1, 0, '0,         0, 1, RX_D);
        for (int i = 0; i < 3; i++)
            add(0, 1, bad,    1, 0, '0,         0, 1, RX_D);
        add(1, 1, d2,         1, 1, d1,         0, 1, RX_D);
        add(1, 0, bad,        0, 0, '0,         0, 1, RX_D);
        add(1, 1, d3,         0, 1, d2,         1, 1, RX_D);
        add(1, 1, t87,        1, 1, d3,         0, 1, RX_D);
        add(1, 0, bad,        0, 0, '0,         0, 1, RX_D);
        add(1, 1, IDLE_BLOCK, 0, 1, t87,        1, 1, RX_T);
        run_vecs("gaps");
        check("gaps.count", 66'(o_error_count), 66'(0));

        // Reset mid-packet flushes the held block
        reset_dut();
        add(1, 1, s1, 0, 0, '0, 0, 0, RX_INIT);
        add(1, 1, d1, 1, 1, s1, 0, 1, RX_D);
        add(1, 1, d2, 0, 1, d1, 1, 1, RX_D);
        run_vecs("midrst_pre");
        i_reset = 1'b1;
        step(1'b1, 1'b1, d3, 1'b1, 1'b0);
        i_reset = 1'b0;
        check("midrst.valid", 66'(o_valid), 66'(0));
        check("midrst.data", o_data, EBLOCK);
        check("midrst.state", 66'(dut.state), 66'(RX_INIT));
        add(1, 1, d3, 1, 0, '0,     0, 1, RX_INIT);
        add(1, 1, d1, 0, 1, EBLOCK, 1, 1, RX_E);
        run_vecs("midrst_post");
        check("midrst.count", 66'(o_error_count), 66'(1));

        // Counter saturation and clear priority
        reset_dut();
        for (int i = 0; i < 65541; i++) begin
            step(1'b1, 1'b1, bad, 1'b0, 1'b0);
            if (i == 65534) check("sat.fffe", 66'(o_error_count), 66'(16'hFFFE));
        end
        check("sat.count", 66'(o_error_count), 66'(16'hFFFF));
        check("sat.data", o_data, EBLOCK);
        check("sat.valid", 66'(o_valid), 66'(1));
        step(1'b1, 1'b1, bad, 1'b0, 1'b1);
        check("clear.count", 66'(o_error_count), 66'(0));
        step(1'b1, 1'b1, bad, 1'b0, 1'b0);
        check("after_clear.count", 66'(o_error_count), 66'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
